change_dispenser: RTL

- Payout end of the ticket counter: accepts a change amount from the ticket FSM over a valid/ready handshake and pays it out as physical coins.
- Drives three coin hoppers one coin at a time and confirms each coin on its exit sensor.
- Pays greedily, largest coin first; reports total paid and any shortfall.
- Sits between the ticket FSM change output and the hopper driver board.

---
 rtl/ticket_pkg.sv | 26 ++
 rtl/change_dispenser_denom_select.sv | 38 +++
 rtl/change_dispenser.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/ticket_pkg.sv
// Shared ticket-counter definitions: payout FSM states, coin values, hopper indices.
`default_nettype none

package ticket_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SELECT     = 3'd1,
    ST_DRIVE      = 3'd2,
    ST_WAIT_SENSE = 3'd3,
    ST_DONE       = 3'd4
  } change_state_t;

  localparam int c_NUM_HOPPERS = 3;

  localparam int c_COIN0_VAL = 50;
  localparam int c_COIN1_VAL = 20;
  localparam int c_COIN2_VAL = 10;

  localparam logic [1:0] c_HOPPER0 = 2'd0;
  localparam logic [1:0] c_HOPPER1 = 2'd1;
  localparam logic [1:0] c_HOPPER2 = 2'd2;

endpackage

`default_nettype wire

// File: rtl/change_dispenser_denom_select.sv
// Combinational priority picker: lowest-index (largest) coin that fits and is available.
`default_nettype none

module denom_select
  import ticket_pkg::*;
#(
  parameter int AMT_W     = 8,
  parameter int COIN0_VAL = c_COIN0_VAL,
  parameter int COIN1_VAL = c_COIN1_VAL,
  parameter int COIN2_VAL = c_COIN2_VAL
) (
  input  logic [AMT_W-1:0]         i_remaining,
  input  logic [c_NUM_HOPPERS-1:0] i_hopper_empty,
  input  logic [c_NUM_HOPPERS-1:0] i_fault,
  output logic                     o_found,
  output logic [1:0]               o_sel
);

  localparam logic [AMT_W-1:0] c_VAL0 = AMT_W'(COIN0_VAL);
  localparam logic [AMT_W-1:0] c_VAL1 = AMT_W'(COIN1_VAL);
  localparam logic [AMT_W-1:0] c_VAL2 = AMT_W'(COIN2_VAL);

  logic [c_NUM_HOPPERS-1:0] w_elig;

  always_comb begin
    w_elig[0] = (c_VAL0 <= i_remaining) && !i_hopper_empty[0] && !i_fault[0];
    w_elig[1] = (c_VAL1 <= i_remaining) && !i_hopper_empty[1] && !i_fault[1];
    w_elig[2] = (c_VAL2 <= i_remaining) && !i_hopper_empty[2] && !i_fault[2];
    o_found   = |w_elig;
    o_sel     = c_HOPPER0;
    if (w_elig[0])      o_sel = c_HOPPER0;
    else if (w_elig[1]) o_sel = c_HOPPER1;
    else if (w_elig[2]) o_sel = c_HOPPER2;
  end

endmodule

`default_nettype wire

// File: rtl/change_dispenser.sv
// Change payout engine: accepts an amount, drives three coin hoppers greedily and
// confirms each coin on its exit sensor, reporting amount paid and shortfall.
`default_nettype none

module change_dispenser
  import ticket_pkg::*;
#(
  parameter int AMT_W          = 8,
  parameter int COIN0_VAL      = c_COIN0_VAL,
  parameter int COIN1_VAL      = c_COIN1_VAL,
  parameter int COIN2_VAL      = c_COIN2_VAL,
  parameter int PULSE_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [AMT_W-1:0]         req_amount,
  output logic [c_NUM_HOPPERS-1:0] hopper_drive,
  input  logic [c_NUM_HOPPERS-1:0] coin_sensed,
  input  logic [c_NUM_HOPPERS-1:0] hopper_empty,
  input  logic                     fault_clear,
  output logic [c_NUM_HOPPERS-1:0] fault,
  output logic                     done,
  output logic [AMT_W-1:0]         dispensed_total,
  output logic [AMT_W-1:0]         shortfall
);

  localparam int PCW = $clog2(PULSE_CYCLES + 1);
  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [PCW-1:0]   c_PULSE_LAST = PCW'(PULSE_CYCLES - 1);
  localparam logic [TW-1:0]    c_TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [AMT_W-1:0] c_VAL0       = AMT_W'(COIN0_VAL);
  localparam logic [AMT_W-1:0] c_VAL1       = AMT_W'(COIN1_VAL);
  localparam logic [AMT_W-1:0] c_VAL2       = AMT_W'(COIN2_VAL);

  change_state_t            r_state;
  change_state_t            w_state_nxt;
  logic                     r_ready_en;
  logic [AMT_W-1:0]         r_remaining;
  logic [AMT_W-1:0]         r_dispensed;
  logic [AMT_W-1:0]         r_total;
  logic [AMT_W-1:0]         r_short;
  logic [1:0]               r_sel;
  logic [PCW-1:0]           r_pulse_cnt;
  logic [TW-1:0]            r_timer;
  logic [c_NUM_HOPPERS-1:0] r_fault;

  logic                     w_found;
  logic [1:0]               w_pick;
  logic [c_NUM_HOPPERS-1:0] w_sel_oh;
  logic [AMT_W-1:0]         w_sel_val;
  logic                     w_sensed;
  logic                     w_accept;
  logic                     w_credit;
  logic                     w_fault_set;

  denom_select #(
    .AMT_W     (AMT_W),
    .COIN0_VAL (COIN0_VAL),
    .COIN1_VAL (COIN1_VAL),
    .COIN2_VAL (COIN2_VAL)
  ) u_denom_select (
    .i_remaining    (r_remaining),
    .i_hopper_empty (hopper_empty),
    .i_fault        (r_fault),
    .o_found        (w_found),
    .o_sel          (w_pick)
  );

  always_comb begin
    w_sel_oh = 3'b001 << r_sel;
    case (r_sel)
      c_HOPPER0: w_sel_val = c_VAL0;
      c_HOPPER1: w_sel_val = c_VAL1;
      default:   w_sel_val = c_VAL2;
    endcase
    // Only the selected hopper's sensor counts; anything else is noise.
    w_sensed = |(coin_sensed & w_sel_oh);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_accept     = 1'b0;
    w_credit     = 1'b0;
    w_fault_set  = 1'b0;
    req_ready    = 1'b0;
    hopper_drive = '0;
    done         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req_ready = r_ready_en;
        if (req_valid && r_ready_en) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_SELECT;
        end
      end
      ST_SELECT: begin
        if (r_remaining == '0 || !w_found) w_state_nxt = ST_DONE;
        else                               w_state_nxt = ST_DRIVE;
      end
      ST_DRIVE: begin
        hopper_drive = w_sel_oh;
        if (w_sensed) begin
          w_credit    = 1'b1;
          w_state_nxt = ST_SELECT;
        end else if (r_pulse_cnt == c_PULSE_LAST) begin
          w_state_nxt = ST_WAIT_SENSE;
        end
      end
      ST_WAIT_SENSE: begin
        if (w_sensed) begin
          w_credit    = 1'b1;
          w_state_nxt = ST_SELECT;
        end else if (r_timer == c_TIMER_LAST) begin
          w_fault_set = 1'b1;
          w_state_nxt = ST_SELECT;
        end
      end
      ST_DONE: begin
        done        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ready_en  <= 1'b0;
      r_remaining <= '0;
      r_dispensed <= '0;
      r_total     <= '0;
      r_short     <= '0;
      r_sel       <= c_HOPPER0;
      r_pulse_cnt <= '0;
      r_timer     <= '0;
      r_fault     <= '0;
    end else begin
      r_ready_en <= 1'b1;
      if (w_accept) begin
        r_remaining <= req_amount;
        r_dispensed <= '0;
        r_total     <= '0;
        r_short     <= '0;
      end
      if (r_state == ST_SELECT) begin
        r_sel       <= w_pick;
        r_pulse_cnt <= '0;
        // Results are latched as DONE is entered so they are valid alongside the done pulse.
        if (w_state_nxt == ST_DONE) begin
          r_total <= r_dispensed;
          r_short <= r_remaining;
        end
      end
      if (r_state == ST_DRIVE) begin
        r_pulse_cnt <= r_pulse_cnt + PCW'(1);
        r_timer     <= '0;
      end
      if (r_state == ST_WAIT_SENSE) r_timer <= r_timer + TW'(1);
      if (w_credit) begin
        r_remaining <= r_remaining - w_sel_val;
        r_dispensed <= r_dispensed + w_sel_val;
      end
      r_fault <= (fault_clear ? '0 : r_fault) | (w_fault_set ? w_sel_oh : '0);
    end
  end

  assign fault           = r_fault;
  assign dispensed_total = r_total;
  assign shortfall       = r_short;

endmodule

`default_nettype wire
